// File: rtl/ibuf_sync_pkg.sv
// ibuf_sync_pkg
//   Shared constants and helpers for the ibuf_sync_filter block.
//   - width_for(): number of bits needed to hold the value max_val (minimum 1),
//     i.e. ceil(log2(max_val+1)); used to size the filter and watchdog counters.
//   - *_MIN / *_MAX: legal parameter bounds, checked at elaboration.
package ibuf_sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int FILT_LEN_MIN    = 1;
  localparam int FILT_LEN_MAX    = 255;

  function automatic int width_for(input int max_val);
    int w;
    w = 1;
    for (int k = 1; k < 31; k++) begin
      if ((1 << k) <= max_val) w = k + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ibuf_sync_cdc.sv
// ibuf_sync_cdc
//   Plain multi-flop synchronizer for one asynchronous level. Kept in its own
//   module so the flop chain can be targeted by CDC timing constraints.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears every stage to 0
//   d     - asynchronous input level
//   q     - synchronized level (last stage of the chain)
module ibuf_sync_cdc #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ibuf_sync_filter.sv
// ibuf_sync_filter
//   Brings the single-ended output of a differential input buffer into the
//   CLK domain, rejects glitches shorter than FILT_LEN synchronized samples,
//   and produces a clean level with registered rise/fall pulses. A watchdog
//   raises STALL when O has not changed for TIMEOUT enabled cycles.
//   There is no handshake: I is a free-running level, O/RISE/FALL/STALL are
//   registered outputs valid every cycle.
// Ports:
//   CLK     - core clock, all state on its rising edge
//   RST_N   - asynchronous active-low reset
//   I       - asynchronous input level
//   EN      - filter/watchdog enable (synchronizer always runs)
//   O       - filtered, synchronized level
//   RISE    - one-cycle pulse in the first cycle O reads 1
//   FALL    - one-cycle pulse in the first cycle O reads 0
//   STALL   - sticky no-transition flag, cleared by the next O transition
//   CNT_CLR - synchronous edge-counter clear
//   CNT     - saturating count of RISE cycles
// Build option:
//   IBUF_SYNC_EDGE_CNT_EN - builds the rising-edge counter; otherwise CNT is
//   tied to 0 and CNT_CLR is unused. The port list is the same either way.
module ibuf_sync_filter
  import ibuf_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT     = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             I,
  input  logic             EN,
  output logic             O,
  output logic             RISE,
  output logic             FALL,
  output logic             STALL,
  input  logic             CNT_CLR,
  output logic [CNT_W-1:0] CNT
);

  generate
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
      $error("ibuf_sync_filter: SYNC_STAGES out of range");
    end
    if (FILT_LEN < FILT_LEN_MIN || FILT_LEN > FILT_LEN_MAX) begin : g_bad_filt
      $error("ibuf_sync_filter: FILT_LEN out of range");
    end
  endgenerate

  localparam int             FW        = width_for(FILT_LEN);
  localparam logic [FW-1:0]  FILT_LAST = FW'(FILT_LEN - 1);

  logic          s;
  logic [FW-1:0] fcnt;
  logic          toggle;

  ibuf_sync_cdc #(
    .STAGES (SYNC_STAGES)
  ) u_cdc (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (I),
    .q     (s)
  );

  // O changes on the edge that would take fcnt past FILT_LEN-1, so FILT_LEN
  // disagreeing samples are needed; FILT_LEN=1 makes O follow S by one cycle.
  assign toggle = EN && (s != O) && (fcnt == FILT_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      O    <= 1'b0;
      fcnt <= '0;
      RISE <= 1'b0;
      FALL <= 1'b0;
    end else begin
      RISE <= toggle && s;
      FALL <= toggle && !s;
      if (toggle) begin
        O    <= s;
        fcnt <= '0;
      end else if (EN && (s != O)) begin
        fcnt <= fcnt + FW'(1);
      end else begin
        // Any agreeing sample, or EN=0, restarts the count.
        fcnt <= '0;
      end
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_no_wd
      assign STALL = 1'b0;
    end else begin : g_wd
      localparam int            WW      = width_for(TIMEOUT);
      localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT);
      localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

      logic [WW-1:0] wcnt;
      logic          stall_q;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          wcnt    <= '0;
          stall_q <= 1'b0;
        end else if (toggle) begin
          wcnt    <= '0;
          stall_q <= 1'b0;
        end else if (EN && (wcnt != WD_MAX)) begin
          wcnt <= wcnt + WW'(1);
          // STALL rises on the same edge wcnt reaches TIMEOUT.
          if (wcnt == WD_LAST) stall_q <= 1'b1;
        end
      end

      assign STALL = stall_q;
    end
  endgenerate

`ifdef IBUF_SYNC_EDGE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Counts cycles in which RISE is high; a clear in a RISE cycle leaves 1.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else if (CNT_CLR) begin
      cnt_q <= CNT_W'(RISE);
    end else if (RISE && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign CNT = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = CNT_CLR;
  assign CNT = '0;
`endif

endmodule
